// File: rtl/kmeans_regfile_gen.sv
// APB register file in front of the k-means core: control/status, indirect RAM
// write port, threshold and centroid registers shared with the running core.
module kmeans_regfile_gen #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 91,
    parameter int NUM_CENT   = 8,
    parameter int RAM_ADDR_W = 9,
    parameter int THR_W      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  irq,
    output logic                  core_go,
    input  logic                  core_done,
    input  logic [IDX_W-1:0]      core_idx,
    input  logic                  core_we,
    input  logic [DATA_W-1:0]     core_wdata,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [RAM_ADDR_W-1:0] first_addr,
    output logic [RAM_ADDR_W-1:0] last_addr,
    output logic [THR_W-1:0]      threshold
);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_RAM_ADDR = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RAM_DATA = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_FIRST    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_LAST     = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_THR      = ADDR_W'(6);
    localparam int                CENT_BASE  = 8;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} apb_state_e;
    apb_state_e state_q, state_d;

    logic                  busy_q, busy_d, done_q, done_d;
    logic                  irq_en_q, auto_inc_q;
    logic [RAM_ADDR_W-1:0] ram_ptr_q, ram_addr_q, first_q, last_q;
    logic [DATA_W-1:0]     ram_wdata_q;
    logic                  ram_cs_n_q, ram_we_n_q;
    logic [THR_W-1:0]      thr_q;
    logic [DATA_W-1:0]     cent_q [NUM_CENT];
    logic [DATA_W-1:0]     core_rdata_q, core_rd_d;
    logic [DATA_W-1:0]     prdata_q, rd_val;
    logic                  pready_q, pslverr_q;
    logic                  mapped, wr_err, acc_err, fire, do_wr, ram_wr;
    logic                  go_wr, clr_wr;
    logic [NUM_CENT-1:0]   cent_hit;

    // APB: setup (psel & ~penable) moves IDLE->ACC; the access is performed on the
    // ACC edge with psel & penable, and pready is then high for exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (psel && !penable) state_d = S_ACC;
            S_ACC:   if (!psel) state_d = S_IDLE;
                     else if (penable) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val   = '0;
        mapped   = 1'b1;
        cent_hit = '0;
        case (paddr)
            A_STATUS:   rd_val = DATA_W'({done_q, busy_q});
            A_CTRL:     rd_val = DATA_W'({auto_inc_q, irq_en_q, 2'b00});
            A_RAM_ADDR: rd_val = DATA_W'(ram_ptr_q);
            A_RAM_DATA: rd_val = ram_wdata_q;
            A_FIRST:    rd_val = DATA_W'(first_q);
            A_LAST:     rd_val = DATA_W'(last_q);
            A_THR:      rd_val = DATA_W'(thr_q);
            default:    mapped = 1'b0;
        endcase
        for (int i = 0; i < NUM_CENT; i++) begin
            if (paddr == ADDR_W'(CENT_BASE + i)) begin
                mapped      = 1'b1;
                rd_val      = cent_q[i];
                cent_hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        core_rd_d = '0;
        for (int i = 0; i < NUM_CENT; i++) begin
            if (core_idx == IDX_W'(i)) core_rd_d = cent_q[i];
        end
    end

    // While the core runs only CTRL stays writable, so host and core never race on CENT.
    assign wr_err  = pwrite && ((paddr == A_STATUS) || (busy_q && (paddr != A_CTRL)));
    assign acc_err = !mapped || wr_err;
    assign fire    = (state_q == S_ACC) && psel && penable;
    assign do_wr   = fire && pwrite && !acc_err;
    assign ram_wr  = do_wr && (paddr == A_RAM_DATA);
    assign go_wr   = do_wr && (paddr == A_CTRL) && pwdata[0];
    assign clr_wr  = do_wr && (paddr == A_CTRL) && pwdata[1];

    // A completion in the same cycle as DONE_CLR leaves done set.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (busy_q && core_done) busy_d = 1'b0;
        else if (!busy_q && go_wr) busy_d = 1'b1;
        if (busy_q && core_done) done_d = 1'b1;
        else if (clr_wr) done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            auto_inc_q   <= 1'b0;
            ram_ptr_q    <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_cs_n_q   <= 1'b1;
            ram_we_n_q   <= 1'b1;
            first_q      <= '0;
            last_q       <= '0;
            thr_q        <= '0;
            core_rdata_q <= '0;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            for (int i = 0; i < NUM_CENT; i++) cent_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_rdata_q <= core_rd_d;
            ram_cs_n_q   <= !ram_wr;
            ram_we_n_q   <= !ram_wr;
            if (fire) begin
                pready_q  <= 1'b1;
                pslverr_q <= acc_err;
                prdata_q  <= (pwrite || acc_err) ? '0 : rd_val;
            end else begin
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end
            if (do_wr && (paddr == A_CTRL)) begin
                irq_en_q   <= pwdata[2];
                auto_inc_q <= pwdata[3];
            end
            if (do_wr && (paddr == A_RAM_ADDR)) ram_ptr_q <= pwdata[RAM_ADDR_W-1:0];
            if (ram_wr) begin
                ram_addr_q  <= ram_ptr_q;
                ram_wdata_q <= pwdata;
                if (auto_inc_q) ram_ptr_q <= ram_ptr_q + RAM_ADDR_W'(1);
            end
            if (do_wr && (paddr == A_FIRST)) first_q <= pwdata[RAM_ADDR_W-1:0];
            if (do_wr && (paddr == A_LAST))  last_q  <= pwdata[RAM_ADDR_W-1:0];
            if (do_wr && (paddr == A_THR))   thr_q   <= pwdata[THR_W-1:0];
            for (int i = 0; i < NUM_CENT; i++) begin
                if (do_wr && cent_hit[i]) cent_q[i] <= pwdata;
                else if (busy_q && core_we && (core_idx == IDX_W'(i))) cent_q[i] <= core_wdata;
            end
        end
    end

    assign prdata     = prdata_q;
    assign pready     = pready_q;
    assign pslverr    = pslverr_q;
    assign irq        = done_q & irq_en_q;
    assign core_go    = busy_q;
    assign core_rdata = core_rdata_q;
    assign ram_cs_n   = ram_cs_n_q;
    assign ram_we_n   = ram_we_n_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign first_addr = first_q;
    assign last_addr  = last_q;
    assign threshold  = thr_q;
endmodule

// File: tb/tb_kmeans_regfile_gen.sv
// Bench for kmeans_regfile_gen: vector table, hand-written corner sequences and
// random traffic checked against a register-level model with a RAM-pulse queue.
module tb_kmeans_regfile_gen;
    localparam int ADDR_W = 9, DATA_W = 91, NUM_CENT = 8, RAM_ADDR_W = 9, THR_W = 16, IDX_W = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [DATA_W-1:0] pwdata = '0, prdata, core_wdata = '0, core_rdata, ram_wdata;
    logic pready, pslverr, irq, core_go, ram_cs_n, ram_we_n;
    logic core_done = 1'b0, core_we = 1'b0;
    logic [IDX_W-1:0] core_idx = '0;
    logic [RAM_ADDR_W-1:0] ram_addr, first_addr, last_addr;
    logic [THR_W-1:0] threshold;

    always #5 clk = ~clk;

    kmeans_regfile_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CENT(NUM_CENT),
                         .RAM_ADDR_W(RAM_ADDR_W), .THR_W(THR_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .irq(irq), .core_go(core_go), .core_done(core_done),
        .core_idx(core_idx), .core_we(core_we), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .first_addr(first_addr),
        .last_addr(last_addr), .threshold(threshold)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-level reference model
    logic                  m_busy, m_done, m_irq_en, m_auto_inc;
    int                    m_ram_addr;
    logic [DATA_W-1:0]     m_ram_data;
    logic [RAM_ADDR_W-1:0] m_first, m_last;
    logic [THR_W-1:0]      m_thr;
    logic [DATA_W-1:0]     m_cent [NUM_CENT];
    logic [RAM_ADDR_W+DATA_W-1:0] exp_q[$];
    logic [RAM_ADDR_W+DATA_W-1:0] e_ram;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_irq_en = 0; m_auto_inc = 0;
        m_ram_addr = 0; m_ram_data = '0; m_first = '0; m_last = '0; m_thr = '0;
        for (int i = 0; i < NUM_CENT; i++) m_cent[i] = '0;
        exp_q.delete();
    endtask

    task automatic model_apb(input logic wr, input int addr, input logic [DATA_W-1:0] d,
                             output logic [DATA_W-1:0] rd, output logic err);
        rd = '0;
        err = (addr == 7) || (addr >= 8 + NUM_CENT) || (wr && addr == 0) || (wr && m_busy && addr != 1);
        if (!err && !wr) begin
            case (addr)
                0: begin rd[0] = m_busy; rd[1] = m_done; end
                1: begin rd[2] = m_irq_en; rd[3] = m_auto_inc; end
                2: rd[RAM_ADDR_W-1:0] = RAM_ADDR_W'(m_ram_addr);
                3: rd = m_ram_data;
                4: rd[RAM_ADDR_W-1:0] = m_first;
                5: rd[RAM_ADDR_W-1:0] = m_last;
                6: rd[THR_W-1:0] = m_thr;
                default: rd = m_cent[addr-8];
            endcase
        end
        if (!err && wr) begin
            case (addr)
                1: begin
                    if (d[0]) m_busy = 1;
                    if (d[1]) m_done = 0;
                    m_irq_en = d[2]; m_auto_inc = d[3];
                end
                2: m_ram_addr = int'(d[RAM_ADDR_W-1:0]);
                3: begin
                    m_ram_data = d;
                    exp_q.push_back({RAM_ADDR_W'(m_ram_addr), d});
                    if (m_auto_inc) m_ram_addr = (m_ram_addr + 1) % (1 << RAM_ADDR_W);
                end
                4: m_first = d[RAM_ADDR_W-1:0];
                5: m_last = d[RAM_ADDR_W-1:0];
                6: m_thr = d[THR_W-1:0];
                default: m_cent[addr-8] = d;
            endcase
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // RAM pulse scoreboard
    always @(negedge clk) begin
        if (ram_cs_n === 1'b0) begin
            if (exp_q.size() == 0) chk("ram_unexpected_pulse", 1, 0);
            else begin
                e_ram = exp_q.pop_front();
                chk("ram_addr", ram_addr, e_ram[RAM_ADDR_W+DATA_W-1:DATA_W]);
                chk("ram_wdata", ram_wdata, e_ram[DATA_W-1:0]);
                chk("ram_we_n", ram_we_n, 0);
            end
        end
    end

    task automatic check_outputs();
        chk("core_go", core_go, m_busy);
        chk("irq", irq, m_done & m_irq_en);
        chk("first_addr", first_addr, m_first);
        chk("last_addr", last_addr, m_last);
        chk("threshold", threshold, m_thr);
    endtask

    task automatic apb(input logic wr, input int addr, input logic [DATA_W-1:0] d, input logic done_on_acc,
                       output logic [DATA_W-1:0] rd, output logic err);
        int lat;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = ADDR_W'(addr); pwdata = d;
        @(negedge clk);
        chk("pready_in_acc", pready, 0);
        penable = 1; core_done = done_on_acc;
        lat = 2;
        @(negedge clk);
        core_done = 0;
        while (pready !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("pready_latency", lat, 2);
        rd = prdata; err = pslverr;
        psel = 0; penable = 0;
        @(negedge clk);
        chk("pready_one_cycle", pready, 0);
        chk("prdata_idle", prdata, 0);
        chk("pslverr_idle", pslverr, 0);
    endtask

    task automatic xfer(input logic wr, input int addr, input logic [DATA_W-1:0] d, input logic done_on_acc,
                        output logic [DATA_W-1:0] rd, output logic err);
        logic [DATA_W-1:0] m_rd;
        logic m_err, was_busy;
        was_busy = m_busy;
        model_apb(wr, addr, d, m_rd, m_err);
        if (done_on_acc && was_busy) begin m_busy = 0; m_done = 1; end
        apb(wr, addr, d, done_on_acc, rd, err);
        if (!wr) chk($sformatf("prdata_a%0d", addr), rd, m_rd);
        chk($sformatf("pslverr_a%0d", addr), err, m_err);
        check_outputs();
    endtask

    task automatic core_write(input int idx, input logic [DATA_W-1:0] d);
        @(negedge clk);
        core_idx = IDX_W'(idx); core_we = 1; core_wdata = d;
        @(negedge clk);
        core_we = 0;
        if (m_busy && idx < NUM_CENT) m_cent[idx] = d;
    endtask

    task automatic core_read(input int idx);
        logic [DATA_W-1:0] exp;
        @(negedge clk);
        core_idx = IDX_W'(idx);
        @(negedge clk);
        exp = (idx < NUM_CENT) ? m_cent[idx] : '0;
        chk($sformatf("core_rdata_i%0d", idx), core_rdata, exp);
    endtask

    task automatic core_done_pulse();
        @(negedge clk);
        core_done = 1;
        @(negedge clk);
        core_done = 0;
        if (m_busy) begin m_busy = 0; m_done = 1; end
    endtask

    typedef struct {
        logic              wr;
        int                addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic wr, input int addr, input logic [DATA_W-1:0] wd,
                           input logic [DATA_W-1:0] erd, input logic eerr);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wd; v.exp_rd = erd; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] rd;
        logic err;
        model_reset();
        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        chk("rst_ram_cs_n", ram_cs_n, 1);
        chk("rst_ram_we_n", ram_we_n, 1);
        chk("rst_pready", pready, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        check_outputs();
        rst_n = 1;

        for (int a = 0; a < 7; a++) add_vec(0, a, '0, '0, 0);
        for (int a = 8; a < 8 + NUM_CENT; a++) add_vec(0, a, '0, '0, 0);
        add_vec(1, 11, 91'h5A5A, '0, 0);
        add_vec(0, 11, '0, 91'h5A5A, 0);
        add_vec(0, 8 + NUM_CENT, '0, '0, 1);
        add_vec(0, 7, '0, '0, 1);
        add_vec(1, 0, 91'h3, '0, 1);
        add_vec(0, 0, '0, '0, 0);
        add_vec(1, 1, 91'h8, '0, 0);
        add_vec(1, 2, 91'd511, '0, 0);
        add_vec(1, 3, 91'd7, '0, 0);
        add_vec(1, 3, 91'd9, '0, 0);
        add_vec(0, 2, '0, 91'd1, 0);
        add_vec(0, 1, '0, 91'h8, 0);
        add_vec(0, 3, '0, 91'd9, 0);
        add_vec(1, 4, 91'h3FF, '0, 0);
        add_vec(1, 5, 91'd300, '0, 0);
        add_vec(1, 6, 91'h1_0000_ABCD, '0, 0);
        add_vec(0, 4, '0, 91'h1FF, 0);
        add_vec(0, 5, '0, 91'd300, 0);
        add_vec(0, 6, '0, 91'hABCD, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rd, err);
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), err, vecs[i].exp_err);
        end
        chk("ram_pulses_done", exp_q.size(), 0);

        // Busy: write protection, core centroid access, GO while busy
        xfer(1, 1, 91'h9, 0, rd, err);
        chk("go_core_go", core_go, 1);
        xfer(1, 6, 91'h1234, 0, rd, err);
        chk("thr_busy_err", err, 1);
        chk("thr_busy_keep", threshold, 16'hABCD);
        xfer(1, 3, 91'd55, 0, rd, err);
        chk("ramdata_busy_err", err, 1);
        core_write(2, 91'h33);
        core_read(2);
        chk("core_rdata_c2", core_rdata, 91'h33);
        core_write(9, 91'h77);
        core_read(9);
        xfer(0, 10, '0, 0, rd, err);
        chk("cent2_apb", rd, 91'h33);
        xfer(1, 1, 91'h9, 0, rd, err);
        chk("go_while_busy_err", err, 0);
        chk("go_while_busy_busy", core_go, 1);

        // Completion, interrupt, clear
        xfer(1, 1, 91'hC, 0, rd, err);
        core_done_pulse();
        check_outputs();
        chk("done_irq", irq, 1);
        xfer(0, 0, '0, 0, rd, err);
        chk("status_done", rd, 91'h2);
        xfer(1, 1, 91'hE, 0, rd, err);
        chk("irq_cleared", irq, 0);

        // core_done coincident with DONE_CLR: done stays set
        xfer(1, 1, 91'h5, 0, rd, err);
        xfer(1, 1, 91'h6, 1, rd, err);
        xfer(0, 0, '0, 0, rd, err);
        chk("done_set_wins", rd, 91'h2);
        core_write(1, 91'hDEAD);
        xfer(0, 9, '0, 0, rd, err);
        chk("core_we_idle_ignored", rd, 0);

        // psel dropped in ACC: no response, no effect
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = ADDR_W'(4); pwdata = 91'd42;
        @(negedge clk);
        psel = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_pready", pready, 0);
        end
        chk("abort_first_keep", first_addr, m_first);

        // Reset during ACC of a write to FIRST
        xfer(1, 4, 91'd0, 0, rd, err);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = ADDR_W'(4); pwdata = 91'd77;
        @(negedge clk);
        penable = 1; rst_n = 0;
        @(negedge clk);
        psel = 0; penable = 0; rst_n = 1;
        model_reset();
        chk("rst_acc_pready", pready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_acc_no_pready", pready, 0);
        end
        chk("rst_acc_first", first_addr, 0);
        xfer(0, 4, '0, 0, rd, err);
        chk("rst_acc_read_first", rd, 0);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5) xfer($urandom_range(0, 1), $urandom_range(0, 8 + NUM_CENT + 1), rand_data(),
                             ($urandom_range(0, 5) == 0), rd, err);
            else if (op == 6) core_done_pulse();
            else if (op == 7) core_write($urandom_range(0, 15), rand_data());
            else core_read($urandom_range(0, 15));
            check_outputs();
        end
        repeat (2) @(negedge clk);
        chk("ram_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
